// File: rtl/fp_pkg.sv
// Shared encodings and format helpers for the parametrised FP multiplier.
package fp_pkg;

  typedef enum logic [1:0] {
    RND_RNE = 2'd0,
    RND_RTZ = 2'd1,
    RND_RUP = 2'd2,
    RND_RDN = 2'd3
  } rndMode_e;

  typedef enum logic [2:0] {
    CLS_NORM = 3'd0,
    CLS_ZERO = 3'd1,
    CLS_SUBN = 3'd2,
    CLS_INF  = 3'd3,
    CLS_NAN  = 3'd4
  } fpClass_e;

  typedef enum logic [1:0] {
    SP_NONE = 2'd0,
    SP_NAN  = 2'd1,
    SP_INF  = 2'd2,
    SP_ZERO = 2'd3
  } special_e;

  localparam int FLG_INVALID   = 4;
  localparam int FLG_DIVZERO   = 3;
  localparam int FLG_OVERFLOW  = 2;
  localparam int FLG_UNDERFLOW = 1;
  localparam int FLG_INEXACT   = 0;

  function automatic int fpBias(input int expW);
    return (1 << (expW - 1)) - 1;
  endfunction

  // Results are right-aligned in 64 bits; callers truncate to their word width.
  function automatic logic [63:0] fpQNan(input int expW, input int manW);
    return (((64'd1 << expW) - 64'd1) << manW) | (64'd1 << (manW - 1));
  endfunction

  function automatic logic [63:0] fpMaxFinite(input int expW, input int manW);
    return (((64'd1 << expW) - 64'd2) << manW) | ((64'd1 << manW) - 64'd1);
  endfunction

endpackage

// File: rtl/fp_classify.sv
// Operand classifier: class, significand with hidden bit (zero for non-normals),
// and signalling-NaN indication. Purely combinational.
module fp_classify
  import fp_pkg::*;
#(
  parameter int pExpW = 8,
  parameter int pManW = 23
) (
  input  logic [pExpW+pManW-1:0] iv_Op,
  output logic [2:0]             ov_Class,
  output logic [pManW:0]         ov_Sig,
  output logic                   o_Snan
);

  logic [pExpW-1:0] expF;
  logic [pManW-1:0] manF;

  assign expF = iv_Op[pExpW+pManW-1:pManW];
  assign manF = iv_Op[pManW-1:0];

  always_comb begin
    ov_Class = CLS_NORM;
    ov_Sig   = {1'b1, manF};
    o_Snan   = 1'b0;
    if (expF == '0) begin
      ov_Class = (manF == '0) ? CLS_ZERO : CLS_SUBN;
      ov_Sig   = '0;
    end else if (expF == '1) begin
      ov_Sig = '0;
      if (manF == '0) begin
        ov_Class = CLS_INF;
      end else begin
        ov_Class = CLS_NAN;
        o_Snan   = ~manF[pManW-1];
      end
    end
  end

endmodule

// File: rtl/fp_mult_pipe.sv
// Pipelined FP multiplier with valid/ready, global stall, per-op rounding mode,
// exception flags and a pass-through tag. Three core stages plus output retiming.
module fp_mult_pipe
  import fp_pkg::*;
#(
  parameter int pExpW     = 8,
  parameter int pManW     = 23,
  parameter int pPipeline = 4,
  parameter int pTagW     = 4
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst,
  input  logic [pExpW+pManW:0]   iv_InputA,
  input  logic [pExpW+pManW:0]   iv_InputB,
  input  logic [1:0]             iv_RndMode,
  input  logic [pTagW-1:0]       iv_Tag,
  input  logic                   i_Valid,
  output logic                   o_Ready,
  output logic [pExpW+pManW:0]   ov_Result,
  output logic [pTagW-1:0]       ov_Tag,
  output logic [4:0]             ov_Flags,
  output logic                   o_Valid,
  input  logic                   i_Ready
);

  localparam int cW  = pExpW + pManW + 1;
  localparam int cM  = pManW + 1;
  localparam int cXW = pExpW + 2;
  localparam int unsigned cDep = pPipeline - 3;

  localparam logic [cW-1:0]          cQNan   = cW'(fpQNan(pExpW, pManW));
  localparam logic [cW-1:0]          cMaxFin = cW'(fpMaxFinite(pExpW, pManW));
  localparam logic signed [cXW-1:0]  cBiasX  = cXW'(fpBias(pExpW));
  localparam logic signed [cXW-1:0]  cExpMax = cXW'((1 << pExpW) - 1);
  localparam logic signed [cXW-1:0]  cOne    = 1;
  localparam logic signed [cXW-1:0]  cZero   = 0;

  logic en;
  assign en      = i_Ready || !o_Valid;
  assign o_Ready = en;

  logic [2:0]     clsA, clsB;
  logic [pManW:0] sigA, sigB;
  logic           snanA, snanB;

  fp_classify #(.pExpW(pExpW), .pManW(pManW)) uClassA (
    .iv_Op(iv_InputA[cW-2:0]), .ov_Class(clsA), .ov_Sig(sigA), .o_Snan(snanA)
  );
  fp_classify #(.pExpW(pExpW), .pManW(pManW)) uClassB (
    .iv_Op(iv_InputB[cW-2:0]), .ov_Class(clsB), .ov_Sig(sigB), .o_Snan(snanB)
  );

  logic             s1Valid, s1Sign, s1SnanA, s1SnanB;
  logic [pTagW-1:0] s1Tag;
  rndMode_e         s1Rnd;
  logic [2:0]       s1ClsA, s1ClsB;
  logic [pManW:0]   s1SigA, s1SigB;
  logic [pExpW-1:0] s1ExpA, s1ExpB;

  logic                   s2Valid, s2Sign, s2Invalid;
  logic [pTagW-1:0]       s2Tag;
  rndMode_e               s2Rnd;
  special_e               s2Special;
  logic [2*cM-1:0]        s2Prod;
  logic signed [cXW-1:0]  s2Exp;

  logic             oValid [0:cDep];
  logic [cW-1:0]    oRes   [0:cDep];
  logic [pTagW-1:0] oTag   [0:cDep];
  logic [4:0]       oFlags [0:cDep];

  // Stage 2 next-state: special-case selection, raw product and biased exponent sum.
  logic                  zA, zB, infA, infB, nanA, nanB, infTimesZero;
  special_e              spNext;
  logic                  invNext;
  logic [2*cM-1:0]       prodNext;
  logic signed [cXW-1:0] expSumNext;

  always_comb begin
    zA   = (s1ClsA == CLS_ZERO) || (s1ClsA == CLS_SUBN);
    zB   = (s1ClsB == CLS_ZERO) || (s1ClsB == CLS_SUBN);
    infA = (s1ClsA == CLS_INF);
    infB = (s1ClsB == CLS_INF);
    nanA = (s1ClsA == CLS_NAN);
    nanB = (s1ClsB == CLS_NAN);
    infTimesZero = (infA && zB) || (infB && zA);
    spNext  = SP_NONE;
    invNext = 1'b0;
    if (nanA || nanB || infTimesZero) begin
      spNext  = SP_NAN;
      invNext = infTimesZero || s1SnanA || s1SnanB;
    end else if (infA || infB) begin
      spNext = SP_INF;
    end else if (zA || zB) begin
      spNext = SP_ZERO;
    end
    prodNext   = (2*cM)'(s1SigA) * (2*cM)'(s1SigB);
    expSumNext = $signed({2'b00, s1ExpA}) + $signed({2'b00, s1ExpB}) - cBiasX;
  end

  // Stage 3 next-state: normalise, round, range-check and merge specials.
  logic [pManW-1:0]      mant;
  logic                  guardB, roundB, stickyB, inexact, up;
  logic [pManW:0]        mRnd;
  logic signed [cXW-1:0] e1, e2;
  logic [cW-1:0]         infRes, maxRes, resNext;
  logic [4:0]            flagsNext;

  always_comb begin
    if (s2Prod[2*cM-1]) begin
      mant    = s2Prod[2*cM-2:cM];
      guardB  = s2Prod[cM-1];
      roundB  = s2Prod[cM-2];
      stickyB = |s2Prod[cM-3:0];
      e1      = s2Exp + cOne;
    end else begin
      mant    = s2Prod[2*cM-3:cM-1];
      guardB  = s2Prod[cM-2];
      roundB  = s2Prod[cM-3];
      stickyB = |s2Prod[cM-4:0];
      e1      = s2Exp;
    end
    inexact = guardB || roundB || stickyB;
    case (s2Rnd)
      RND_RNE: up = guardB && (roundB || stickyB || mant[0]);
      RND_RTZ: up = 1'b0;
      RND_RUP: up = inexact && !s2Sign;
      default: up = inexact && s2Sign;
    endcase
    // A rounding carry leaves the low mantissa bits at zero, so only the exponent moves.
    mRnd = {1'b0, mant} + {{pManW{1'b0}}, up};
    e2   = e1 + $signed({{(cXW-1){1'b0}}, mRnd[pManW]});

    infRes    = {s2Sign, {pExpW{1'b1}}, {pManW{1'b0}}};
    maxRes    = {s2Sign, cMaxFin[cW-2:0]};
    resNext   = {s2Sign, e2[pExpW-1:0], mRnd[pManW-1:0]};
    flagsNext = '0;
    case (s2Special)
      SP_NAN: begin
        resNext = cQNan;
        flagsNext[FLG_INVALID] = s2Invalid;
      end
      SP_INF:  resNext = infRes;
      SP_ZERO: resNext = {s2Sign, {(cW-1){1'b0}}};
      default: begin
        if (e2 >= cExpMax) begin
          flagsNext[FLG_OVERFLOW] = 1'b1;
          flagsNext[FLG_INEXACT]  = 1'b1;
          case (s2Rnd)
            RND_RNE: resNext = infRes;
            RND_RTZ: resNext = maxRes;
            RND_RUP: resNext = s2Sign ? maxRes : infRes;
            default: resNext = s2Sign ? infRes : maxRes;
          endcase
        end else if (e2 <= cZero) begin
          resNext = {s2Sign, {(cW-1){1'b0}}};
          flagsNext[FLG_UNDERFLOW] = 1'b1;
          flagsNext[FLG_INEXACT]   = 1'b1;
        end else begin
          flagsNext[FLG_INEXACT] = inexact;
        end
      end
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      s1Valid <= 1'b0;
      s2Valid <= 1'b0;
      for (int unsigned i = 0; i <= cDep; i++) begin
        oValid[i] <= 1'b0;
        oRes[i]   <= '0;
        oTag[i]   <= '0;
        oFlags[i] <= '0;
      end
    end else if (en) begin
      s1Valid <= i_Valid;
      s1Tag   <= iv_Tag;
      s1Rnd   <= rndMode_e'(iv_RndMode);
      s1Sign  <= iv_InputA[cW-1] ^ iv_InputB[cW-1];
      s1ClsA  <= clsA;
      s1ClsB  <= clsB;
      s1SigA  <= sigA;
      s1SigB  <= sigB;
      s1SnanA <= snanA;
      s1SnanB <= snanB;
      s1ExpA  <= iv_InputA[cW-2:pManW];
      s1ExpB  <= iv_InputB[cW-2:pManW];

      s2Valid   <= s1Valid;
      s2Tag     <= s1Tag;
      s2Rnd     <= s1Rnd;
      s2Sign    <= s1Sign;
      s2Special <= spNext;
      s2Invalid <= invNext;
      s2Prod    <= prodNext;
      s2Exp     <= expSumNext;

      oValid[0] <= s2Valid;
      oRes[0]   <= resNext;
      oTag[0]   <= s2Tag;
      oFlags[0] <= flagsNext;
      for (int unsigned i = 1; i <= cDep; i++) begin
        oValid[i] <= oValid[i-1];
        oRes[i]   <= oRes[i-1];
        oTag[i]   <= oTag[i-1];
        oFlags[i] <= oFlags[i-1];
      end
    end
  end

  assign o_Valid   = oValid[cDep];
  assign ov_Result = oRes[cDep];
  assign ov_Tag    = oTag[cDep];
  assign ov_Flags  = oFlags[cDep];

endmodule
